alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal values 4..32, power of two).
REQ-002 Parameter SAT_EN, default 1, 1 = saturation logic present; 0 = i_sat ignored.
REQ-003 Parameter CNT_WIDTH, default 8, width of overflow event counter.
REQ-004 i_CLK  input  1  single clock; all state changes on rising edge.
REQ-005 i_RSTn  input  1  asynchronous, active-low reset.
REQ-006 i_arg0  input  WIDTH  signed operand A.
REQ-007 i_arg1  input  WIDTH  signed operand B.
REQ-008 i_oper  input  3  opcode.
REQ-009 i_sat  input  1  per-operation saturate request, sampled with operands.
REQ-010 i_valid  input  1  operand set valid.
REQ-011 o_ready  output  1  block can accept operand set this cycle.
REQ-012 o_result  output  WIDTH  signed result.
REQ-013 o_flag  output  4  {V, C, N, Z}.
REQ-014 o_valid  output  1  o_result/o_flag valid.
REQ-015 i_ready  input  1  downstream accepts result.
REQ-016 i_cnt_clr  input  1  synchronous clear of overflow counter.
REQ-017 o_ovf_cnt  output  CNT_WIDTH  count of delivered results with V=1.

Function
REQ-018 Opcodes: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 SHL A by B[log2(WIDTH)-1:0], 110 ASR A by same amount, 111 MUL signed, low WIDTH bits.
REQ-019 Two-stage pipeline: stage 1 registers operands/opcode/sat on accept (i_valid && o_ready); stage 2 registers computed result and flags.
REQ-020 Latency: o_valid asserts exactly 2 cycles after accept when i_ready held high; throughput 1 op/cycle.
REQ-021 Each stage loads when empty or when its contents advance the same cycle; o_ready = stage 1 empty or stage 1 advancing.
REQ-022 With i_ready=0, o_result, o_flag, o_valid hold stable; no op dropped, duplicated or reordered.
REQ-023 Z = (result == 0); N = result MSB; both from final (possibly clamped) result.
REQ-024 C: ADD carry-out of unsigned sum; SUB borrow (unsigned A < B); SHL/ASR last bit shifted out, 0 for zero shift; logic and MUL C=0.
REQ-025 V: ADD/SUB signed overflow; MUL full signed product not representable in WIDTH; all other ops V=0.
REQ-026 When SAT_EN=1 and i_sat=1, ADD/SUB/MUL overflow clamps to +2^(WIDTH-1)-1 (positive) or -2^(WIDTH-1) (negative); V still reported 1.
REQ-027 o_ovf_cnt increments by 1 on each o_valid && i_ready with V=1; saturates at all-ones, no wrap.
REQ-028 i_cnt_clr clears counter next edge; clear wins over a simultaneous increment.
REQ-029 Shift amount >= WIDTH impossible by masking; shift of 0 returns A unchanged.

Reset
REQ-030 i_RSTn=0 immediately forces o_valid=0, o_result=0, o_flag=0, o_ovf_cnt=0, both stages empty, regardless of clock.
REQ-031 o_ready SHALL be 0 while i_RSTn=0 and 1 in the first cycle after release.
REQ-032 Reset mid-operation discards all in-flight ops; none emerge after release.

Verification (WIDTH=8, SAT_EN=1)
REQ-033 ADD 100+50, i_sat=0 -> two cycles later o_result=0x96 (-106), flags V=1 C=0 N=1 Z=0, counter 1.
REQ-034 ADD 100+50, i_sat=1 -> o_result=0x7F, V=1 C=0 N=0 Z=0; SUB -100-50 sat -> 0x80, V=1.
REQ-035 SUB 0-1 -> 0xFF, C=1 N=1 V=0 Z=0; XOR 0x5A^0x5A -> 0x00, Z=1, C=V=0.
REQ-036 MUL -3*5 -> 0xF1, V=0; MUL 16*16 -> 0x00, Z=1 V=1; ASR 0x80 by 3 -> 0xF0, C=0; SHL 0x81 by 1 -> 0x02, C=1.
REQ-037 Hold i_ready=0, drive 4 back-to-back valid ops -> o_ready drops after 2 accepted, outputs stable; release -> both delivered in order, remaining ops then accepted, none lost.
REQ-038 Both stages full, pulse i_RSTn low mid-cycle -> o_valid, o_result, o_flag, o_ovf_cnt go 0 asynchronously; no stale op appears after release; i_cnt_clr with concurrent V=1 delivery -> counter 0.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined signed ALU with valid/ready handshaking,
// optional saturation on ADD/SUB/MUL overflow, {V,C,N,Z} flags and a
// saturating counter of delivered results that overflowed.
module alu_pipe #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SAT_EN    = 1'b1,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 i_CLK,
  input  logic                 i_RSTn,
  input  logic [WIDTH-1:0]     i_arg0,
  input  logic [WIDTH-1:0]     i_arg1,
  input  logic [2:0]           i_oper,
  input  logic                 i_sat,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [WIDTH-1:0]     o_result,
  output logic [3:0]           o_flag,
  output logic                 o_valid,
  input  logic                 i_ready,
  input  logic                 i_cnt_clr,
  output logic [CNT_WIDTH-1:0] o_ovf_cnt
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_ASR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  // Stage 1: captured operand set
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  op_e              s1_op_q, s1_op_d;
  logic             s1_sat_q, s1_sat_d;

  // Stage 2: computed result and flags
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flag_q, flag_d;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Handshake and datapath intermediates
  logic               s2_free;
  logic               accept;
  logic [SHW-1:0]     shamt;
  logic [WIDTH:0]     sum_w, diff_w, shl_w, asr_w;
  logic [2*WIDTH-1:0] prod_w, prod_sext;
  logic [WIDTH-1:0]   alu_res;
  logic [3:0]         alu_flag;
  logic               carry, ovf, clamp_neg;

  // Handshake: stage 2 is free when empty or draining; stage 1 takes new data
  // when empty or when its contents move into stage 2 this cycle.
  always_comb begin
    s2_free = !s2_valid_q || i_ready;
    o_ready = i_RSTn && (!s1_valid_q || s2_free);
    accept  = i_valid && o_ready;
  end

  // Stage 1 next state: load on accept, empty when the op moves on.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_sat_d   = s1_sat_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = i_arg0;
      s1_b_d     = i_arg1;
      s1_op_d    = op_e'(i_oper);
      s1_sat_d   = i_sat;
    end else if (s1_valid_q && s2_free) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 1 occupancy register.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of block ordering.
    if (!i_RSTn) s1_valid_q <= 1'b0;
    else         s1_valid_q <= s1_valid_d;
  end

  // Stage 1 payload register.
  always_ff @(posedge i_CLK) begin
    // NOTE: the payload is left unreset; s1_valid_q qualifies it, so its
    // contents are never observed before a real accept.
    s1_a_q   <= s1_a_d;
    s1_b_q   <= s1_b_d;
    s1_op_q  <= s1_op_d;
    s1_sat_q <= s1_sat_d;
  end

  // ALU: result, carry, overflow and optional clamp for the stage 1 op.
  always_comb begin
    shamt     = s1_b_q[SHW-1:0];
    sum_w     = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    diff_w    = {1'b0, s1_a_q} - {1'b0, s1_b_q};
    shl_w     = {1'b0, s1_a_q} << shamt;
    // Extra low bit catches the last bit shifted out; stays 0 for shamt 0.
    asr_w     = $signed({s1_a_q, 1'b0}) >>> shamt;
    prod_w    = $signed({{WIDTH{s1_a_q[WIDTH-1]}}, s1_a_q}) *
                $signed({{WIDTH{s1_b_q[WIDTH-1]}}, s1_b_q});
    prod_sext = {{WIDTH{prod_w[WIDTH-1]}}, prod_w[WIDTH-1:0]};
    alu_res   = '0;
    carry     = 1'b0;
    ovf       = 1'b0;
    clamp_neg = 1'b0;
    case (s1_op_q)
      OP_ADD: begin
        alu_res   = sum_w[WIDTH-1:0];
        carry     = sum_w[WIDTH];
        ovf       = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &&
                    (sum_w[WIDTH-1] != s1_a_q[WIDTH-1]);
        clamp_neg = s1_a_q[WIDTH-1];
      end
      OP_SUB: begin
        alu_res   = diff_w[WIDTH-1:0];
        carry     = diff_w[WIDTH];
        ovf       = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                    (diff_w[WIDTH-1] != s1_a_q[WIDTH-1]);
        clamp_neg = s1_a_q[WIDTH-1];
      end
      OP_AND: alu_res = s1_a_q & s1_b_q;
      OP_OR:  alu_res = s1_a_q | s1_b_q;
      OP_XOR: alu_res = s1_a_q ^ s1_b_q;
      OP_SHL: begin
        alu_res = shl_w[WIDTH-1:0];
        carry   = shl_w[WIDTH];
      end
      OP_ASR: begin
        alu_res = asr_w[WIDTH:1];
        carry   = asr_w[0];
      end
      OP_MUL: begin
        alu_res   = prod_w[WIDTH-1:0];
        ovf       = (prod_w != prod_sext);
        clamp_neg = prod_w[2*WIDTH-1];
      end
      default: alu_res = '0;
    endcase
    if (SAT_EN && s1_sat_q && ovf) alu_res = clamp_neg ? MIN_NEG : MAX_POS;
    alu_flag = {ovf, carry, alu_res[WIDTH-1], (alu_res == '0)};
  end

  // Stage 2 next state: take stage 1 contents whenever stage 2 is free.
  always_comb begin
    s2_valid_d = s2_valid_q;
    res_d      = res_q;
    flag_d     = flag_q;
    if (s2_free) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_d  = alu_res;
        flag_d = alu_flag;
      end
    end
  end

  // Stage 2 registers; outputs must read zero during reset.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      flag_q     <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      flag_q     <= flag_d;
    end
  end

  // Overflow counter: clear wins, otherwise count delivered V=1 results,
  // sticking at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (i_cnt_clr) begin
      cnt_d = '0;
    end else if (s2_valid_q && i_ready && flag_q[3] && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // Overflow counter register.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign o_valid   = s2_valid_q;
  assign o_result  = res_q;
  assign o_flag    = flag_q;
  assign o_ovf_cnt = cnt_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vector table, stall/reset/clear sequences and a
// randomized run, all scored against an arithmetic reference model.
module tb_alu_pipe;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
  localparam logic [2:0] XOR_ = 3'd4, SHL = 3'd5, ASR = 3'd6, MUL = 3'd7;

  logic       clk;
  logic       rst_n;
  logic [7:0] i_arg0, i_arg1;
  logic [2:0] i_oper;
  logic       i_sat, i_valid, i_ready, i_cnt_clr;
  logic       o_ready, o_valid;
  logic [7:0] o_result;
  logic [3:0] o_flag;
  logic [7:0] o_ovf_cnt;

  alu_pipe #(.WIDTH(8), .SAT_EN(1'b1), .CNT_WIDTH(8)) dut (
    .i_CLK     (clk),
    .i_RSTn    (rst_n),
    .i_arg0    (i_arg0),
    .i_arg1    (i_arg1),
    .i_oper    (i_oper),
    .i_sat     (i_sat),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_result  (o_result),
    .o_flag    (o_flag),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .i_cnt_clr (i_cnt_clr),
    .o_ovf_cnt (o_ovf_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [7:0] res;
    logic [3:0] flag;
  } exp_t;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       sat;
    logic [7:0] res;
    logic [3:0] flag;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];
  logic [7:0] exp_cnt = 8'd0;
  bit         held = 1'b0;
  logic [7:0] held_res;
  logic [3:0] held_flag;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the signed operand values.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic [2:0] op, input logic sat);
    int   sa, sbv, ua, ub, n, r;
    bit   c, v;
    exp_t e;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    ua  = int'(a);
    ub  = int'(b);
    n   = int'(b[2:0]);
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      ADD: begin r = sa + sbv; c = (ua + ub) > 255; v = (r > 127) || (r < -128); end
      SUB: begin r = sa - sbv; c = ua < ub;         v = (r > 127) || (r < -128); end
      AND_: r = ua & ub;
      OR_:  r = ua | ub;
      XOR_: r = ua ^ ub;
      SHL: begin r = ua << n; c = (n != 0) && (((ua >> (8 - n)) & 1) != 0); end
      ASR: begin r = sa >>> n; c = (n != 0) && (((sa >>> (n - 1)) & 1) != 0); end
      default: begin r = sa * sbv; v = (r > 127) || (r < -128); end
    endcase
    if (v && sat) r = (r > 0) ? 127 : -128;
    e.res  = r[7:0];
    e.flag = {v, c, e.res[7], (e.res == 8'd0)};
    return e;
  endfunction

  // Scoreboard monitor: inputs and outputs are stable at the falling edge, so
  // the transfers about to happen on the next rising edge are decided here.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      exp_cnt = 8'd0;
      held    = 1'b0;
    end else begin
      bit   ovf_ev;
      exp_t e;
      ovf_ev = 1'b0;
      check("ovf_cnt_track", o_ovf_cnt, exp_cnt);
      if (held) begin
        check("hold_valid", o_valid, 1);
        check("hold_result", o_result, held_res);
        check("hold_flag", o_flag, held_flag);
      end
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_delivery: got o_valid=1 result 0x%0h expected no pending op", o_result);
        end else begin
          e = sb.pop_front();
          check("sb_result", o_result, e.res);
          check("sb_flag", o_flag, e.flag);
          ovf_ev = e.flag[3];
        end
      end
      if (i_cnt_clr) exp_cnt = 8'd0;
      else if (ovf_ev && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      if (i_valid && o_ready) sb.push_back(model(i_arg0, i_arg1, i_oper, i_sat));
      held      = o_valid && !i_ready;
      held_res  = o_result;
      held_flag = o_flag;
    end
  end

  task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic sat);
    i_valid = v;
    i_oper  = op;
    i_arg0  = a;
    i_arg1  = b;
    i_sat   = sat;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t       vecs[18];
  int         exp_ovf;
  int         idx;
  bit         acc;
  logic [7:0] qa[4];

  initial begin
    vecs[0]  = '{"add_ovf",     8'd100, 8'd50,  ADD,  1'b0, 8'h96, 4'b1010};
    vecs[1]  = '{"add_sat",     8'd100, 8'd50,  ADD,  1'b1, 8'h7F, 4'b1000};
    vecs[2]  = '{"sub_sat",     8'h9C,  8'd50,  SUB,  1'b1, 8'h80, 4'b1010};
    vecs[3]  = '{"sub_borrow",  8'h00,  8'h01,  SUB,  1'b0, 8'hFF, 4'b0110};
    vecs[4]  = '{"xor_zero",    8'h5A,  8'h5A,  XOR_, 1'b0, 8'h00, 4'b0001};
    vecs[5]  = '{"mul_neg",     8'hFD,  8'h05,  MUL,  1'b0, 8'hF1, 4'b0010};
    vecs[6]  = '{"mul_ovf",     8'h10,  8'h10,  MUL,  1'b0, 8'h00, 4'b1001};
    vecs[7]  = '{"asr3",        8'h80,  8'h03,  ASR,  1'b0, 8'hF0, 4'b0010};
    vecs[8]  = '{"shl1",        8'h81,  8'h01,  SHL,  1'b0, 8'h02, 4'b0100};
    vecs[9]  = '{"shl_mask0",   8'h81,  8'h08,  SHL,  1'b0, 8'h81, 4'b0010};
    vecs[10] = '{"asr7",        8'hC1,  8'h07,  ASR,  1'b0, 8'hFF, 4'b0110};
    vecs[11] = '{"mul_sat_pos", 8'h80,  8'hFF,  MUL,  1'b1, 8'h7F, 4'b1000};
    vecs[12] = '{"and",         8'hF0,  8'h3C,  AND_, 1'b0, 8'h30, 4'b0000};
    vecs[13] = '{"or_zero",     8'h00,  8'h00,  OR_,  1'b0, 8'h00, 4'b0001};
    vecs[14] = '{"add_carry",   8'hFF,  8'h01,  ADD,  1'b0, 8'h00, 4'b0101};
    vecs[15] = '{"mul_sat_neg", 8'h80,  8'h02,  MUL,  1'b1, 8'h80, 4'b1010};
    vecs[16] = '{"sub_ovf_pos", 8'h7F,  8'hFF,  SUB,  1'b0, 8'h80, 4'b1110};
    vecs[17] = '{"shl7",        8'h03,  8'h07,  SHL,  1'b0, 8'h80, 4'b0110};

    rst_n     = 1'b0;
    i_ready   = 1'b0;
    i_cnt_clr = 1'b0;
    drive(1'b0, ADD, 8'd0, 8'd0, 1'b0);

    // Reset state
    #3;
    check("rst_valid", o_valid, 0);
    check("rst_result", o_result, 0);
    check("rst_flag", o_flag, 0);
    check("rst_cnt", o_ovf_cnt, 0);
    check("rst_ready", o_ready, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", o_ready, 1);
    next_cycle();

    // Directed vectors with latency check
    i_ready = 1'b1;
    exp_ovf = 0;
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sat);
      next_cycle();
      drive(1'b0, ADD, 8'd0, 8'd0, 1'b0);
      check({"lat1_", vecs[i].name}, o_valid, 0);
      next_cycle();
      check({"lat2_", vecs[i].name}, o_valid, 1);
      check({"res_", vecs[i].name}, o_result, vecs[i].res);
      check({"flag_", vecs[i].name}, o_flag, vecs[i].flag);
      if (vecs[i].flag[3]) exp_ovf++;
    end
    next_cycle();
    next_cycle();
    check("ovf_cnt_table", o_ovf_cnt, exp_ovf);

    // Back-pressure: four back-to-back ops against a stalled sink
    qa[0] = 8'd1; qa[1] = 8'd3; qa[2] = 8'd5; qa[3] = 8'd7;
    i_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      if (idx < 4) drive(1'b1, ADD, qa[idx], 8'd2, 1'b0);
      else         drive(1'b0, ADD, 8'd0, 8'd0, 1'b0);
      @(negedge clk);
      acc = o_ready;
      next_cycle();
      if (acc) idx++;
    end
    check("stall_accepted", idx, 2);
    check("stall_ready_low", o_ready, 0);
    check("stall_first_out", o_result, 8'd3);
    i_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (idx < 4) drive(1'b1, ADD, qa[idx], 8'd2, 1'b0);
      else         drive(1'b0, ADD, 8'd0, 8'd0, 1'b0);
      @(negedge clk);
      acc = o_ready;
      next_cycle();
      if (acc && idx < 4) idx++;
    end
    check("stall_all_accepted", idx, 4);
    check("stall_sb_empty", sb.size(), 0);

    // Counter clear racing a V=1 delivery
    drive(1'b1, ADD, 8'd100, 8'd50, 1'b0);
    next_cycle();
    drive(1'b0, ADD, 8'd0, 8'd0, 1'b0);
    i_cnt_clr = 1'b1;
    next_cycle();
    i_cnt_clr = 1'b0;
    check("clr_pre_cnt", o_ovf_cnt, 0);
    next_cycle();
    check("clr_one_cnt", o_ovf_cnt, 1);
    drive(1'b1, ADD, 8'd100, 8'd50, 1'b0);
    next_cycle();
    drive(1'b0, ADD, 8'd0, 8'd0, 1'b0);
    next_cycle();
    check("clr_race_valid", o_valid, 1);
    i_cnt_clr = 1'b1;
    next_cycle();
    i_cnt_clr = 1'b0;
    check("clr_wins", o_ovf_cnt, 0);
    check("clr_delivered", o_valid, 0);

    // Counter saturation
    drive(1'b1, ADD, 8'd100, 8'd50, 1'b0);
    for (int c = 0; c < 270; c++) next_cycle();
    drive(1'b0, ADD, 8'd0, 8'd0, 1'b0);
    for (int c = 0; c < 4; c++) next_cycle();
    check("cnt_saturated", o_ovf_cnt, 8'hFF);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      drive($urandom_range(9) < 7, 3'($urandom_range(7)), 8'($urandom),
            8'($urandom), 1'($urandom_range(1)));
      i_ready   = $urandom_range(9) < 7;
      i_cnt_clr = ($urandom_range(63) == 0);
      next_cycle();
    end
    drive(1'b0, ADD, 8'd0, 8'd0, 1'b0);
    i_ready   = 1'b1;
    i_cnt_clr = 1'b0;
    for (int c = 0; c < 5; c++) next_cycle();
    check("rand_sb_empty", sb.size(), 0);

    // Reset with both stages full
    i_ready = 1'b0;
    drive(1'b1, ADD, 8'd100, 8'd50, 1'b0);
    next_cycle();
    next_cycle();
    drive(1'b0, ADD, 8'd0, 8'd0, 1'b0);
    check("full_valid", o_valid, 1);
    check("full_ready", o_ready, 0);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_valid", o_valid, 0);
    check("async_result", o_result, 0);
    check("async_flag", o_flag, 0);
    check("async_cnt", o_ovf_cnt, 0);
    check("async_ready", o_ready, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("ready_after_midrst", o_ready, 1);
    i_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      check("no_stale_op", o_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
